// File: rtl/piso_tx_shifter_if.sv
// Load/serial bus of piso_tx_shifter: the load handshake going in and the serial stream coming out.
// Handshake: a word is taken on a rising edge where load_valid && load_ready; sout/done mean something only while sout_valid is 1.
interface piso_tx_shifter_if #(
  parameter int WIDTH = 4
);
  logic             dir;
  logic             load_valid;
  logic [WIDTH-1:0] din;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output dir, load_valid, din,
    input  load_ready, sout, sout_valid, done
  );

  modport slave (
    input  dir, load_valid, din,
    output load_ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_tx_shifter.sv
// Parallel-in serial-out transmitter: a word is loaded by handshake and sent one bit per clock, MSB or LSB first.
// Optional feature macro PISO_TX_PARITY_EN: adds one even-parity bit after the data bits.
module piso_tx_shifter #(
  parameter int WIDTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  piso_tx_shifter_if.slave  bus,
  output logic              o_dbg_state
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
`ifdef PISO_TX_PARITY_EN
  logic             r_par;
`endif

  logic w_load;
  logic w_load_ready;
  logic w_sout;
  logic w_sout_valid;
  logic w_done;

  assign w_load = bus.load_valid && w_load_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_load) w_next_state = ST_SHIFT;
      ST_SHIFT: if ((r_cnt == '0) && !w_load) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output logic; ready reopens on the last bit so frames can stream gaplessly.
  always_comb begin
    w_load_ready = 1'b0;
    w_sout       = 1'b0;
    w_sout_valid = 1'b0;
    w_done       = 1'b0;
    if (r_state == ST_SHIFT) begin
      w_sout_valid = 1'b1;
      w_done       = (r_cnt == '0);
      w_load_ready = !i_rst && (r_cnt == '0);
      w_sout       = r_dir ? r_shreg[0] : r_shreg[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
      if (r_cnt == '0) w_sout = r_par;
`endif
    end else begin
      w_load_ready = !i_rst;
    end
  end

  // Datapath: word, bit order and counter are frozen at load time.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_load) begin
      r_shreg <= bus.din;
      r_dir   <= bus.dir;
      r_cnt   <= LAST_CNT;
`ifdef PISO_TX_PARITY_EN
      r_par   <= ^bus.din;
`endif
    end else if (r_state == ST_SHIFT) begin
      r_shreg <= r_dir ? (r_shreg >> 1) : (r_shreg << 1);
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.sout       = w_sout;
  assign bus.sout_valid = w_sout_valid;
  assign bus.done       = w_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_piso_tx_shifter.sv
// Directed bench for piso_tx_shifter: reset, both bit orders, streaming, mid-frame reset, receiver loopback, parity.
module tb_piso_tx_shifter;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  piso_tx_shifter_if #(.WIDTH(WIDTH)) bus ();

  piso_tx_shifter #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  // Bidirectional serial-in receiver fed by the transmitter
  logic             rx_clr = 1'b1;
  logic             rx_dir = 1'b0;
  logic [WIDTH-1:0] rx_q;
  always @(posedge clk) begin
    if (rx_clr) rx_q <= '0;
    else if (bus.sout_valid) rx_q <= rx_dir ? {bus.sout, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], bus.sout};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.load_valid = 1'b1; bus.din = 4'b1011; bus.dir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++; if (bus.load_ready !== 1'b0) $display("FAIL reset_ready[%0d]: got %b want 0", i, bus.load_ready); else n_pass++;
      n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", i, bus.sout_valid); else n_pass++;
      n_checks++; if (bus.sout !== 1'b0) $display("FAIL reset_sout[%0d]: got %b want 0", i, bus.sout); else n_pass++;
      n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", i, bus.done); else n_pass++;
      n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state[%0d]: got %b want 0", i, dbg_state); else n_pass++;
    end
    rst = 1'b0; bus.load_valid = 1'b0;
    #1;
    n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.load_ready); else n_pass++;
    tick;
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", bus.sout_valid); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_release_state: got %b want 0", dbg_state); else n_pass++;
  endtask

  task automatic test_msb_first;
    logic [0:0] e;
    exp_q = {1'b1, 1'b0, 1'b1, 1'b1};
    bus.load_valid = 1'b1; bus.din = 4'b1011; bus.dir = 1'b0;
    n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL msb_ready_idle: got %b want 1", bus.load_ready); else n_pass++;
    tick;
    bus.load_valid = 1'b0; bus.din = 4'b0100; bus.dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (bus.sout_valid !== 1'b1) $display("FAIL msb_valid[%0d]: got %b want 1", i, bus.sout_valid); else n_pass++;
      n_checks++; if (bus.sout !== e) $display("FAIL msb_sout[%0d]: got %b want %b", i, bus.sout, e); else n_pass++;
      n_checks++; if (bus.done !== (i == 3)) $display("FAIL msb_done[%0d]: got %b want %b", i, bus.done, (i == 3)); else n_pass++;
      n_checks++; if (bus.load_ready !== (i == 3)) $display("FAIL msb_ready[%0d]: got %b want %b", i, bus.load_ready, (i == 3)); else n_pass++;
      tick;
    end
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL msb_valid_after: got %b want 0", bus.sout_valid); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL msb_done_after: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.sout !== 1'b0) $display("FAIL msb_sout_after: got %b want 0", bus.sout); else n_pass++;
  endtask

  task automatic test_lsb_first;
    logic [0:0] e;
    exp_q = {1'b1, 1'b1, 1'b0, 1'b1};
    bus.load_valid = 1'b1; bus.din = 4'b1011; bus.dir = 1'b1;
    tick;
    bus.load_valid = 1'b0; bus.din = 4'b0000; bus.dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (bus.sout_valid !== 1'b1) $display("FAIL lsb_valid[%0d]: got %b want 1", i, bus.sout_valid); else n_pass++;
      n_checks++; if (bus.sout !== e) $display("FAIL lsb_sout[%0d]: got %b want %b", i, bus.sout, e); else n_pass++;
      n_checks++; if (bus.done !== (i == 3)) $display("FAIL lsb_done[%0d]: got %b want %b", i, bus.done, (i == 3)); else n_pass++;
      tick;
    end
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL lsb_valid_after: got %b want 0", bus.sout_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [0:0] e;
    exp_q = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.load_valid = 1'b1; bus.din = 4'b1011; bus.dir = 1'b0;
    tick;
    bus.din = 4'b0110;
    for (int i = 1; i <= 8; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (bus.sout_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.sout_valid); else n_pass++;
      n_checks++; if (bus.sout !== e) $display("FAIL b2b_sout[%0d]: got %b want %b", i, bus.sout, e); else n_pass++;
      n_checks++; if (bus.done !== (i == 4 || i == 8)) $display("FAIL b2b_done[%0d]: got %b want %b", i, bus.done, (i == 4 || i == 8)); else n_pass++;
      n_checks++; if (bus.load_ready !== (i == 4 || i == 8)) $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.load_ready, (i == 4 || i == 8)); else n_pass++;
      tick;
      if (i == 4) begin
        bus.load_valid = 1'b0; bus.din = 4'b1111;
      end
    end
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL b2b_valid_after: got %b want 0", bus.sout_valid); else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [0:0] e;
    bus.load_valid = 1'b1; bus.din = 4'b1111; bus.dir = 1'b0;
    tick;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus.sout !== 1'b1) $display("FAIL midrst_pre_sout[%0d]: got %b want 1", i, bus.sout); else n_pass++;
      if (i == 1) rst = 1'b1;
      tick;
    end
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.sout_valid); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.sout !== 1'b0) $display("FAIL midrst_sout: got %b want 0", bus.sout); else n_pass++;
    n_checks++; if (bus.load_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", bus.load_ready); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL midrst_state: got %b want 0", dbg_state); else n_pass++;
    rst = 1'b0;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    bus.load_valid = 1'b1; bus.din = 4'b0101; bus.dir = 1'b0;
    #1;
    n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL midrst_ready_release: got %b want 1", bus.load_ready); else n_pass++;
    tick;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (bus.sout !== e) $display("FAIL midrst_sout[%0d]: got %b want %b", i, bus.sout, e); else n_pass++;
      n_checks++; if (bus.done !== (i == 3)) $display("FAIL midrst_done[%0d]: got %b want %b", i, bus.done, (i == 3)); else n_pass++;
      tick;
    end
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL midrst_valid_after: got %b want 0", bus.sout_valid); else n_pass++;
  endtask

  task automatic test_loopback;
    for (int d = 0; d < 2; d++) begin
      rx_clr = 1'b1; rx_dir = d[0];
      tick;
      rx_clr = 1'b0;
      bus.load_valid = 1'b1; bus.din = 4'b1001; bus.dir = d[0];
      tick;
      bus.load_valid = 1'b0; bus.din = 4'b0110; bus.dir = ~d[0];
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (bus.done !== (i == 3)) $display("FAIL loop_done[dir%0d][%0d]: got %b want %b", d, i, bus.done, (i == 3)); else n_pass++;
        tick;
      end
      n_checks++; if (rx_q !== 4'b1001) $display("FAIL loop_rx[dir%0d]: got %b want 1001", d, rx_q); else n_pass++;
    end
    rx_clr = 1'b1;
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity;
    logic [0:0] e;
    exp_q = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.load_valid = 1'b1; bus.din = 4'b1011; bus.dir = 1'b0;
    tick;
    bus.load_valid = 1'b0; bus.din = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_checks++; if (bus.sout_valid !== 1'b1) $display("FAIL par_valid[%0d]: got %b want 1", i, bus.sout_valid); else n_pass++;
      n_checks++; if (bus.sout !== e) $display("FAIL par_sout[%0d]: got %b want %b", i, bus.sout, e); else n_pass++;
      n_checks++; if (bus.done !== (i == 4)) $display("FAIL par_done[%0d]: got %b want %b", i, bus.done, (i == 4)); else n_pass++;
      n_checks++; if (bus.load_ready !== (i == 4)) $display("FAIL par_ready[%0d]: got %b want %b", i, bus.load_ready, (i == 4)); else n_pass++;
      tick;
    end
    n_checks++; if (bus.sout_valid !== 1'b0) $display("FAIL par_valid_after: got %b want 0", bus.sout_valid); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; bus.load_valid = 1'b0; bus.din = '0; bus.dir = 1'b0;
    test_reset;
`ifdef PISO_TX_PARITY_EN
    test_parity;
`else
    test_msb_first;
    test_lsb_first;
    test_back_to_back;
    test_mid_reset;
    test_loopback;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
